// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the datapath controller and alu_seq.
// The controller drives the request side; the ALU drives status and results.
interface alu_seq_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [1:0]   ALUOp;
  logic         l;
  logic         m;
  logic         busy;
  logic         done;
  logic [N-1:0] R;
  logic [N-1:0] RH;
  logic         zero;
  logic         carry;
  logic         sign;
  logic         overflow;

  modport master (
    output start, A, B, ALUOp, l, m,
    input  busy, done, R, RH, zero, carry, sign, overflow
  );

  modport slave (
    input  start, A, B, ALUOp, l, m,
    output busy, done, R, RH, zero, carry, sign, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered N-bit ALU with start/done handshake: single-cycle arithmetic/logic ops
// and an N-step unsigned shift-add multiply producing a 2N-bit product on RH:R.
module alu_seq #(
  parameter int N = 4
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  rh_q, rh_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          sign_q, sign_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;

  logic [N-1:0]  op1;
  logic [N-1:0]  op2;
  logic [N-1:0]  op2_eff;
  logic          cpl;
  logic [N:0]    sum;
  logic [N-1:0]  alu_r;
  logic          alu_carry;
  logic          alu_ovf;
  logic [N:0]    mul_sum;
  logic [N-1:0]  step_hi;
  logic [N-1:0]  step_lo;

  // Every arithmetic op is op1 + (cpl ? ~op2 : op2) + cpl; negation uses op1 = 0.
  always_comb begin
    op1 = '0;
    op2 = bus.B;
    cpl = 1'b0;
    case (bus.ALUOp)
      2'b00: begin
        op2 = bus.A;
        cpl = 1'b1;
      end
      2'b01: cpl = 1'b1;
      2'b10: op1 = bus.A;
      default: begin
        op1 = bus.A;
        cpl = 1'b1;
      end
    endcase
    op2_eff = cpl ? ~op2 : op2;
    sum     = {1'b0, op1} + {1'b0, op2_eff} + {{N{1'b0}}, cpl};

    alu_r     = sum[N-1:0];
    alu_carry = sum[N];
    alu_ovf   = (op1[N-1] == op2_eff[N-1]) && (sum[N-1] != op1[N-1]);
    if (bus.l) begin
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus.ALUOp)
        2'b00:   alu_r = bus.A & bus.B;
        2'b01:   alu_r = bus.A | bus.B;
        2'b10:   alu_r = bus.A ^ bus.B;
        default: alu_r = ~bus.A;
      endcase
    end
  end

  // One shift-add step: conditionally add the multiplicand, then shift hi:lo right.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    step_hi = mul_sum[N:1];
    step_lo = {mul_sum[0], lo_q[N-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    rh_d       = rh_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.m) begin
            state_d = MUL;
            a_d     = bus.A;
            lo_d    = bus.B;
            hi_d    = '0;
            cnt_d   = '0;
          end else begin
            r_d        = alu_r;
            rh_d       = '0;
            zero_d     = (alu_r == '0);
            carry_d    = alu_carry;
            sign_d     = alu_r[N-1];
            overflow_d = alu_ovf;
            done_d     = 1'b1;
          end
        end
      end
      MUL: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d    = IDLE;
          r_d        = step_lo;
          rh_d       = step_hi;
          zero_d     = ({step_hi, step_lo} == '0);
          carry_d    = |step_hi;
          sign_d     = step_hi[N-1];
          overflow_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      r_q        <= '0;
      rh_q       <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      rh_q       <= rh_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == MUL);
  assign bus.done     = done_q;
  assign bus.R        = r_q;
  assign bus.RH       = rh_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.sign     = sign_q;
  assign bus.overflow = overflow_q;
endmodule
